// File: rtl/fetch_pq.sv
// fetch_pq: instruction-fetch unit with a QDEPTH-entry prefetch queue feeding decode.
// One outstanding I-cache request; redirects flush the queue, faults and misalignment halt fetch.
module fetch_pq #(
    parameter int              XLEN     = 32,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            icache_req_o,
    output logic [XLEN-1:0] icache_addr_o,
    input  logic            icache_ack_i,
    input  logic [31:0]     icache_rdata_i,
    input  logic            page_fault_i,
    input  logic            csr_new_pc_req_i,
    input  logic [XLEN-1:0] csr_pc_new_i,
    input  logic            exe_new_pc_req_i,
    input  logic [XLEN-1:0] exe_pc_new_i,
    input  logic            wfi_req_i,
    input  logic            id_ready_i,
    output logic            id_valid_o,
    output logic [31:0]     id_instr_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic            id_exc_valid_o,
    output logic [3:0]      id_exc_code_o
);
    localparam int          AW  = $clog2(QDEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [AW:0] QD  = (AW+1)'(QDEPTH);

    typedef enum logic [1:0] {S_RESET, S_RUN, S_WFI, S_HALT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [AW:0]     count_q, count_d;
    logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [XLEN-1:0] q_pc    [QDEPTH];
    logic [31:0]     q_instr [QDEPTH];
    logic            q_exc   [QDEPTH];
    logic [3:0]      q_code  [QDEPTH];
    logic            redirect, space, ack, fault, misalign, push, pop;
    logic [XLEN-1:0] target;

    assign redirect = (csr_new_pc_req_i || exe_new_pc_req_i) && state_q != S_RESET;
    assign target   = csr_new_pc_req_i ? csr_pc_new_i : exe_pc_new_i;
    assign space    = count_q < QD;
    assign ack      = icache_req_o && icache_ack_i;
    assign fault    = ack && page_fault_i;
    // Ack and pop in a redirect cycle are dropped along with the flushed queue.
    assign push     = !redirect && (ack || misalign);
    assign pop      = !redirect && id_valid_o && id_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RESET;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_RESET)     state_d = S_RUN;
        else if (redirect)          state_d = S_RUN;
        else if (fault || misalign) state_d = S_HALT;
        else if (state_q == S_RUN && wfi_req_i) state_d = S_WFI;
    end

    always_comb begin
        icache_req_o = state_q == S_RUN && pc_q[1:0] == 2'b00 && space;
        misalign     = state_q == S_RUN && pc_q[1:0] != 2'b00 && space;
    end

    always_comb begin
        pc_d    = redirect ? target : (ack && !page_fault_i) ? pc_q + XLEN'(4) : pc_q;
        count_d = redirect ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
        rd_d    = redirect ? '0 : rd_q + AW'(pop);
        wr_d    = redirect ? '0 : wr_q + AW'(push);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_q]    <= pc_q;
            q_instr[wr_q] <= (fault || misalign) ? NOP : icache_rdata_i;
            q_exc[wr_q]   <= fault || misalign;
            q_code[wr_q]  <= fault ? 4'd12 : 4'd0;
        end
    end

    assign icache_addr_o  = pc_q;
    assign id_valid_o     = count_q != '0;
    assign id_instr_o     = id_valid_o ? q_instr[rd_q] : NOP;
    assign id_pc_o        = id_valid_o ? q_pc[rd_q] : '0;
    assign id_exc_valid_o = id_valid_o && q_exc[rd_q];
    assign id_exc_code_o  = id_valid_o ? q_code[rd_q] : 4'd0;
endmodule

// File: tb/tb_fetch_pq.sv
// tb_fetch_pq: randomized fetch/redirect/fault/WFI traffic against a queue-based reference model.
module tb_fetch_pq;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          QD  = 4;
    localparam int          M_RESET = 0, M_RUN = 1, M_WFI = 2, M_HALT = 3;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        icache_req_o, icache_ack_i, page_fault_i;
    logic [31:0] icache_addr_o, icache_rdata_i;
    logic        csr_new_pc_req_i, exe_new_pc_req_i, wfi_req_i, id_ready_i;
    logic [31:0] csr_pc_new_i, exe_pc_new_i;
    logic        id_valid_o, id_exc_valid_o;
    logic [31:0] id_instr_o, id_pc_o;
    logic [3:0]  id_exc_code_o;

    fetch_pq #(.XLEN(32), .QDEPTH(QD), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .icache_req_o(icache_req_o), .icache_addr_o(icache_addr_o),
        .icache_ack_i(icache_ack_i), .icache_rdata_i(icache_rdata_i), .page_fault_i(page_fault_i),
        .csr_new_pc_req_i(csr_new_pc_req_i), .csr_pc_new_i(csr_pc_new_i),
        .exe_new_pc_req_i(exe_new_pc_req_i), .exe_pc_new_i(exe_pc_new_i),
        .wfi_req_i(wfi_req_i), .id_ready_i(id_ready_i),
        .id_valid_o(id_valid_o), .id_instr_o(id_instr_o), .id_pc_o(id_pc_o),
        .id_exc_valid_o(id_exc_valid_o), .id_exc_code_o(id_exc_code_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
        logic [3:0]  code;
    } ent_t;

    ent_t        mq[$];
    int          mstate;
    logic [31:0] mpc;
    int          total = 0, bad = 0;
    int          ready_pct = 50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_req();
        return mstate == M_RUN && mpc[1:0] == 2'b00 && mq.size() < QD;
    endfunction

    task automatic model_reset();
        mq.delete();
        mstate = M_RESET;
        mpc    = 32'h0;
    endtask

    task automatic check_outputs();
        logic v;
        v = mq.size() > 0;
        chk("req",   32'(icache_req_o), 32'(m_req()));
        chk("addr",  icache_addr_o, mpc);
        chk("valid", 32'(id_valid_o), 32'(v));
        chk("instr", id_instr_o, v ? mq[0].instr : NOP);
        chk("pc",    id_pc_o, v ? mq[0].pc : 32'h0);
        chk("exc",   32'(id_exc_valid_o), v ? 32'(mq[0].exc) : 32'h0);
        chk("code",  32'(id_exc_code_o), v ? 32'(mq[0].code) : 32'h0);
    endtask

    // Advances the model across the coming rising edge using the inputs now applied.
    task automatic model_step();
        logic req, mis;
        ent_t e;
        req = m_req();
        mis = mstate == M_RUN && mpc[1:0] != 2'b00 && mq.size() < QD;
        if (mstate == M_RESET) begin
            mstate = M_RUN;
            return;
        end
        if (csr_new_pc_req_i || exe_new_pc_req_i) begin
            mq.delete();
            mpc    = csr_new_pc_req_i ? csr_pc_new_i : exe_pc_new_i;
            mstate = M_RUN;
            return;
        end
        if (mq.size() > 0 && id_ready_i) void'(mq.pop_front());
        if (req && icache_ack_i) begin
            if (page_fault_i) begin
                e = '{pc: mpc, instr: NOP, exc: 1'b1, code: 4'd12};
                mq.push_back(e);
                mstate = M_HALT;
            end else begin
                e = '{pc: mpc, instr: icache_rdata_i, exc: 1'b0, code: 4'd0};
                mq.push_back(e);
                mpc = mpc + 32'd4;
                if (wfi_req_i) mstate = M_WFI;
            end
        end else if (mis) begin
            e = '{pc: mpc, instr: NOP, exc: 1'b1, code: 4'd0};
            mq.push_back(e);
            mstate = M_HALT;
        end else if (mstate == M_RUN && wfi_req_i) begin
            mstate = M_WFI;
        end
    endtask

    function automatic logic [31:0] rand_target();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return 32'hFFFF_FFF8;
        if (r < 3)  return 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
        return 32'($urandom_range(0, 31)) * 4;
    endfunction

    task automatic randomize_inputs(input int i);
        if (i % 40 == 0) ready_pct = $urandom_range(0, 100);
        icache_ack_i     = $urandom_range(0, 3) != 0;
        icache_rdata_i   = $urandom;
        page_fault_i     = $urandom_range(0, 40) == 0;
        csr_new_pc_req_i = $urandom_range(0, 50) == 0;
        exe_new_pc_req_i = $urandom_range(0, 25) == 0;
        csr_pc_new_i     = rand_target();
        exe_pc_new_i     = rand_target();
        wfi_req_i        = $urandom_range(0, 50) == 0;
        id_ready_i       = $urandom_range(1, 100) <= ready_pct;
    endtask

    initial begin
        icache_ack_i = 0; icache_rdata_i = 0; page_fault_i = 0;
        csr_new_pc_req_i = 0; exe_new_pc_req_i = 0; csr_pc_new_i = 0; exe_pc_new_i = 0;
        wfi_req_i = 0; id_ready_i = 0;
        model_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4000; i++) begin
            check_outputs();
            if (i == 2000) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check_outputs();
            end
            rst_n = 1'b1;
            randomize_inputs(i);
            model_step();
            @(negedge clk);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_pq.md
# fetch_pq

Parametrised instruction-fetch unit with an instruction prefetch queue, the successor to the single-entry `fetch` stage of the pcore pipeline. It sits between the I-cache/MMU and the decode stage. It generates sequential PCs, issues one outstanding I-cache request at a time, and buffers up to `QDEPTH` fetched instructions, or exception entries, for decode. It also handles CSR/EXE redirects, WFI and fetch-exception halting.

## Interface
- `XLEN`, 32, PC/address width
- `QDEPTH`, 4, prefetch queue entries; power of two, ≥ 2
- `RESET_PC`, 32'h0000_0000, PC after reset
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `icache_req_o`  out  1  fetch request valid
- `icache_addr_o`  out  XLEN  fetch address (= fetch_pc)
- `icache_ack_i`  in  1  response valid this cycle; counted only when `icache_req_o`=1
- `icache_rdata_i`  in  32  instruction word, valid with ack
- `page_fault_i`  in  1  instruction page fault, qualified by ack
- `csr_new_pc_req_i`  in  1  CSR redirect (highest priority)
- `csr_pc_new_i`  in  XLEN  CSR redirect target
- `exe_new_pc_req_i`  in  1  EXE redirect (branch/jump)
- `exe_pc_new_i`  in  XLEN  EXE redirect target
- `wfi_req_i`  in  1  wait-for-interrupt: stop fetching
- `id_ready_i`  in  1  decode accepts head entry
- `id_valid_o`  out  1  queue non-empty
- `id_instr_o`  out  32  head instruction
- `id_pc_o`  out  XLEN  head PC
- `id_exc_valid_o`  out  1  head entry is an exception
- `id_exc_code_o`  out  4  head exception cause (0 misaligned, 12 page fault)

## Operation
- **States:** RESET, RUN, WFI, HALT.
  - RESET → RUN unconditionally on the first clock edge after `rst_n` rises.
- **Request generation:** `icache_req_o = (state==RUN) && fetch_pc[1:0]==0 && count<QDEPTH`. It is combinational from registers.
  - The request is held with a stable address until ack.
  - Ack may arrive in the same cycle as the request.
- **Ack** (req && ack):
  - Without page fault: push {fetch_pc, rdata, exc=0}, then fetch_pc += 4 (wraps modulo 2^XLEN).
  - With `page_fault_i`: push {fetch_pc, 32'h0000_0013, exc=1, code=12}. fetch_pc is unchanged and state → HALT.
- **Misaligned PC:** in RUN with fetch_pc[1:0]≠0 and count<QDEPTH, no request is issued. The unit pushes {fetch_pc, NOP, exc=1, code=0} and state → HALT.
- **HALT:** no requests, no pushes. The queue keeps draining to decode. The state is left only by a redirect.
- **WFI:** `wfi_req_i` in RUN → WFI.
  - An ack in the same cycle is still pushed.
  - WFI issues no requests and is left only by a redirect.
  - `wfi_req_i` in HALT/WFI is ignored.
- **Redirect:**
  - Priority: CSR > EXE, and any redirect > WFI.
  - Effect in any non-RESET state: the queue is flushed (count=0), fetch_pc ← target, state → RUN.
  - An ack and a pop in the redirect cycle are discarded.
  - `icache_req_o` reflects the new PC from the next cycle.
- **Queue:** circular FIFO. Pop occurs when `id_valid_o && id_ready_i`.
  - Simultaneous push+pop keeps count unchanged.
  - A push never overflows, because a request requires count<QDEPTH and only one request is outstanding.
  - Pointers are log2(QDEPTH) bits and wrap naturally. count is log2(QDEPTH)+1 bits.
- **Head outputs:** when empty, `id_instr_o`=32'h0000_0013 and the other head fields are 0.

## Timing
- **Reset values:** state=RESET, fetch_pc=RESET_PC, count=0.
  - Outputs during reset: `icache_req_o`=0, `icache_addr_o`=RESET_PC, `id_valid_o`=0, `id_instr_o`=NOP, `id_pc_o`=0, `id_exc_valid_o`=0, `id_exc_code_o`=0.
- First `icache_req_o` is asserted one cycle after `rst_n` deasserts.
- **Fetch→decode latency:** an entry pushed on edge N is visible on `id_*` after edge N, if the queue was empty.
- **Throughput:** 1 instr/cycle with a zero-wait-state cache and `id_ready_i`=1.
- **Redirect latency:** redirect sampled on edge N; the request to the target is visible after edge N; the first target instruction reaches decode one edge later, given a zero-wait ack.
- Reset asserted mid-request or mid-drain clears everything immediately (asynchronous).

## Test plan
- **Reset/stream:** release reset with RESET_PC=0, ack=1, rdata=NOP, id_ready=1 → addresses 0x0, 0x4, 0x8 on consecutive cycles; id_pc follows one cycle behind; id_exc_valid=0.
- **Backpressure/full:** QDEPTH=4, id_ready=0 → exactly 4 pushes (PC 0x0–0xC), then req=0; raise id_ready → pops 0x0 and fetching resumes at 0x10 with no PC gaps.
- **Misaligned redirect:** CSR redirect to 0x2 → no I-cache request; a single entry {pc=0x2, exc=1, code=0}; HALT until CSR redirect to 0x0, after which fetching resumes at 0x0.
- **Page fault:** `page_fault_i`=1 with ack at PC 0x8 → entry {pc=0x8, code=12}; req=0 afterwards; fetch_pc stays 0x8 until a redirect.
- **Simultaneous events:** CSR (0x20), EXE (0x40) and wfi all asserted in one cycle, with an ack pending → queue flushed, ack discarded, next request address 0x20, state RUN.
- **WFI and stall:** `wfi_req_i` pulse → requests stop while queued entries drain; EXE redirect to 0x40 resumes fetching. `icache_ack_i`=0 for 3 cycles → req held with a stable address and no pushes.
